controle_valvula_nivel: RTL and testbench

- Automatic inlet-valve sequencer for the tank.
- Consumes the latest ultrasonic distance measurement (cm, sensor to water surface) and the 6-bit binary thresholds (critico/alto/baixo) plus the manual/abrir_valv mode bits held by the serial configuration registers.
- Drives the valve, with confirmation filtering, hysteresis, overflow protection and sensor-timeout safety.
- Sits between the measurement block and the valve driver; its debug state feeds the 7-segment display.

---
 rtl/controle_valvula_nivel_pkg.sv | 26 ++
 rtl/controle_valvula_nivel_contador_confirmacao.sv | 25 ++
 rtl/controle_valvula_nivel.sv | 143 ++++++++++++++
 tb/tb_controle_valvula_nivel.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/controle_valvula_nivel_pkg.sv
// Shared state codes, threshold types and helpers for the
// tank inlet-valve sequencer.
package controle_valvula_nivel_pkg;

    localparam int LARG_ESTADO = 3;

    localparam logic [LARG_ESTADO-1:0] FECHADA  = 3'd0;
    localparam logic [LARG_ESTADO-1:0] ENCHENDO = 3'd1;
    localparam logic [LARG_ESTADO-1:0] MANUAL   = 3'd2;
    localparam logic [LARG_ESTADO-1:0] CRITICO  = 3'd3;
    localparam logic [LARG_ESTADO-1:0] FALHA    = 3'd4;

    typedef logic [5:0] dist_t;

    typedef struct packed {
        dist_t crit;
        dist_t alto;
        dist_t baixo;
    } limiares_t;

    // Thresholds are distances: overflow is nearest the sensor.
    function automatic logic config_invalida(input limiares_t l);
        return !((l.crit < l.alto) && (l.alto < l.baixo));
    endfunction

endpackage

// File: rtl/controle_valvula_nivel_contador_confirmacao.sv
// Saturating confirmation counter; done marks the sample
// that reaches (or holds) the count N.
module contador_confirmacao #(
    parameter int N = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [3:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset || clr)
            cnt <= '0;
        else if (en && cnt != 4'(N))
            cnt <= cnt + 4'd1;
    end

    // Independent of clr so the caller may clear on the state change it causes.
    assign done = en && (cnt >= 4'(N - 1));

endmodule

// File: rtl/controle_valvula_nivel.sv
// Inlet-valve sequencer: confirmation filtering, hysteresis,
// overflow protection and sensor-timeout safety.
module controle_valvula_nivel
    import controle_valvula_nivel_pkg::*;
#(
    parameter int N_CONFIRM      = 3,
    parameter int TIMEOUT_CICLOS = 50000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   medida_pronta,
    input  logic [5:0]             distancia,
    input  logic [5:0]             nv_crit,
    input  logic [5:0]             nv_alto,
    input  logic [5:0]             nv_baixo,
    input  logic                   manual,
    input  logic                   abrir_valv,
    output logic                   valvula,
    output logic                   alarme_critico,
    output logic                   erro_sensor,
    output logic                   erro_config,
    output logic [LARG_ESTADO-1:0] db_estado
);

    localparam int LT = $clog2(TIMEOUT_CICLOS + 1);

    logic [LARG_ESTADO-1:0] estado;
    logic [LARG_ESTADO-1:0] estado_nxt;
    logic [LT-1:0]          cnt_to;
    limiares_t              lim;
    logic                   timeout;
    logic                   abaixo_crit;
    logic                   acima_alto;
    logic                   crit_en;
    logic                   crit_clr;
    logic                   crit_done;
    logic                   conf_qual;
    logic                   conf_en;
    logic                   conf_clr;
    logic                   conf_done;
    logic [LARG_ESTADO-1:0] destino_saida;

    assign lim         = '{crit: nv_crit, alto: nv_alto, baixo: nv_baixo};
    assign timeout     = (estado != FALHA) &&
                         (cnt_to == LT'(TIMEOUT_CICLOS - 1));
    assign abaixo_crit = distancia <= nv_crit;
    assign acima_alto  = distancia > nv_alto;
    assign destino_saida = manual ? MANUAL : FECHADA;

    always_ff @(posedge clock) begin
        if (!reset || medida_pronta || estado == FALHA)
            cnt_to <= '0;
        else
            cnt_to <= cnt_to + LT'(1);
    end

    // Critical detection runs in every state but FALHA; CRITICO holds it clear.
    assign crit_en  = medida_pronta && abaixo_crit &&
                      (estado != FALHA) && (estado != CRITICO);
    assign crit_clr = (estado == FALHA) || (estado == CRITICO) || timeout ||
                      (medida_pronta && !abaixo_crit);

    contador_confirmacao #(.N(N_CONFIRM)) u_crit (
        .clock (clock),
        .reset (reset),
        .clr   (crit_clr),
        .en    (crit_en),
        .done  (crit_done)
    );

    always_comb begin
        conf_qual = 1'b0;
        case (estado)
            FECHADA:  conf_qual = (distancia >= nv_baixo) && !erro_config;
            ENCHENDO: conf_qual = distancia <= nv_alto;
            CRITICO:  conf_qual = acima_alto;
            default:  conf_qual = 1'b0;
        endcase
    end

    assign conf_en  = medida_pronta && conf_qual;
    assign conf_clr = (medida_pronta && !conf_qual) || (estado_nxt != estado);

    contador_confirmacao #(.N(N_CONFIRM)) u_conf (
        .clock (clock),
        .reset (reset),
        .clr   (conf_clr),
        .en    (conf_en),
        .done  (conf_done)
    );

    always_comb begin
        estado_nxt = estado;
        if (timeout) begin
            estado_nxt = FALHA;
        end else if (estado == FALHA) begin
            if (medida_pronta)
                estado_nxt = destino_saida;
        end else if (crit_done) begin
            estado_nxt = CRITICO;
        end else begin
            case (estado)
                CRITICO: begin
                    if (conf_done)
                        estado_nxt = destino_saida;
                end
                MANUAL: begin
                    if (!manual)
                        estado_nxt = FECHADA;
                end
                FECHADA, ENCHENDO: begin
                    if (erro_config)
                        estado_nxt = FECHADA;
                    else if (manual)
                        estado_nxt = MANUAL;
                    else if (conf_done)
                        estado_nxt = (estado == FECHADA) ? ENCHENDO : FECHADA;
                end
                default: estado_nxt = FECHADA;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado         <= FECHADA;
            valvula        <= 1'b0;
            alarme_critico <= 1'b0;
            erro_sensor    <= 1'b0;
            erro_config    <= 1'b0;
        end else begin
            estado         <= estado_nxt;
            valvula        <= (estado_nxt == ENCHENDO) ||
                              ((estado_nxt == MANUAL) && abrir_valv);
            alarme_critico <= estado_nxt == CRITICO;
            erro_sensor    <= estado_nxt == FALHA;
            erro_config    <= config_invalida(lim);
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_controle_valvula_nivel.sv
// Directed bench for the inlet-valve sequencer.
// Thresholds 3/12/27, one sample every 10 cycles.
module tb_controle_valvula_nivel;

    logic       clock = 1'b0;
    logic       reset;
    logic       medida_pronta;
    logic [5:0] distancia;
    logic [5:0] nv_crit;
    logic [5:0] nv_alto;
    logic [5:0] nv_baixo;
    logic       manual;
    logic       abrir_valv;
    logic       valvula;
    logic       alarme_critico;
    logic       erro_sensor;
    logic       erro_config;
    logic [2:0] db_estado;

    int n_checks = 0;
    int n_erros  = 0;

    always #5 clock = ~clock;

    controle_valvula_nivel #(
        .N_CONFIRM      (3),
        .TIMEOUT_CICLOS (100)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .medida_pronta  (medida_pronta),
        .distancia      (distancia),
        .nv_crit        (nv_crit),
        .nv_alto        (nv_alto),
        .nv_baixo       (nv_baixo),
        .manual         (manual),
        .abrir_valv     (abrir_valv),
        .valvula        (valvula),
        .alarme_critico (alarme_critico),
        .erro_sensor    (erro_sensor),
        .erro_config    (erro_config),
        .db_estado      (db_estado)
    );

    task automatic verifica(input string tag, input int obs, input int esp);
        n_checks++;
        if (obs != esp) begin
            n_erros++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // Nine idle cycles, then a one-cycle pulse; returns 1 time unit after
    // the edge that captured the sample.
    task automatic amostra(input logic [5:0] d);
        repeat (9) @(posedge clock);
        #1;
        medida_pronta = 1'b1;
        distancia     = d;
        @(posedge clock);
        #1;
        medida_pronta = 1'b0;
    endtask

    task automatic amostras(input logic [5:0] d, input int n);
        for (int i = 0; i < n; i++)
            amostra(d);
    endtask

    initial begin
        reset         = 1'b0;
        medida_pronta = 1'b0;
        distancia     = 6'd0;
        nv_crit       = 6'd3;
        nv_alto       = 6'd12;
        nv_baixo      = 6'd27;
        manual        = 1'b0;
        abrir_valv    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        verifica("rst_valv",   int'(valvula),        0);
        verifica("rst_alarme", int'(alarme_critico), 0);
        verifica("rst_esens",  int'(erro_sensor),    0);
        verifica("rst_ecfg",   int'(erro_config),    0);
        verifica("rst_estado", int'(db_estado),      0);
        reset = 1'b1;

        // Fill cycle
        amostras(6'd30, 2);
        verifica("fill_2_estado", int'(db_estado), 0);
        amostra(6'd30);
        verifica("fill_3_valv",   int'(valvula),   1);
        verifica("fill_3_estado", int'(db_estado), 1);
        amostras(6'd10, 2);
        amostra(6'd20);
        amostras(6'd10, 2);
        verifica("close_part_estado", int'(db_estado), 1);
        verifica("close_part_valv",   int'(valvula),   1);
        amostra(6'd10);
        verifica("close_valv",   int'(valvula),   0);
        verifica("close_estado", int'(db_estado), 0);

        // Critical entry from ENCHENDO, hysteresis on exit
        amostras(6'd30, 3);
        verifica("crit_pre_estado", int'(db_estado), 1);
        amostras(6'd2, 2);
        verifica("crit_2_estado", int'(db_estado), 1);
        amostra(6'd2);
        verifica("crit_valv",   int'(valvula),        0);
        verifica("crit_alarme", int'(alarme_critico), 1);
        verifica("crit_estado", int'(db_estado),      3);
        amostras(6'd8, 3);
        verifica("crit_hold8", int'(db_estado), 3);
        amostras(6'd15, 2);
        amostra(6'd8);
        amostras(6'd15, 2);
        verifica("crit_hyst", int'(db_estado), 3);
        amostra(6'd15);
        verifica("crit_exit_estado", int'(db_estado),      0);
        verifica("crit_exit_alarme", int'(alarme_critico), 0);

        // Manual override, then critical overrides manual
        manual     = 1'b1;
        abrir_valv = 1'b1;
        @(posedge clock);
        #1;
        verifica("man_valv",   int'(valvula),   1);
        verifica("man_estado", int'(db_estado), 2);
        abrir_valv = 1'b0;
        @(posedge clock);
        #1;
        verifica("man_fecha", int'(valvula), 0);
        abrir_valv = 1'b1;
        amostras(6'd3, 2);
        verifica("man_crit2", int'(db_estado), 2);
        amostra(6'd3);
        verifica("man_crit_estado", int'(db_estado), 3);
        verifica("man_crit_valv",   int'(valvula),   0);
        manual     = 1'b0;
        abrir_valv = 1'b0;
        amostras(6'd20, 3);
        verifica("man_crit_exit", int'(db_estado), 0);

        // Sensor timeout
        repeat (95) @(posedge clock);
        #1;
        verifica("to_antes", int'(erro_sensor), 0);
        repeat (10) @(posedge clock);
        #1;
        verifica("to_esens",  int'(erro_sensor), 1);
        verifica("to_valv",   int'(valvula),     0);
        verifica("to_estado", int'(db_estado),   4);
        amostra(6'd20);
        verifica("to_sai_estado", int'(db_estado),   0);
        verifica("to_sai_esens",  int'(erro_sensor), 0);

        // Inconsistent thresholds inhibit filling
        nv_alto  = 6'd30;
        nv_baixo = 6'd27;
        repeat (2) @(posedge clock);
        #1;
        verifica("cfg_erro", int'(erro_config), 1);
        amostras(6'd40, 3);
        verifica("cfg_valv",   int'(valvula),   0);
        verifica("cfg_estado", int'(db_estado), 0);
        nv_alto  = 6'd12;
        nv_baixo = 6'd27;
        repeat (2) @(posedge clock);
        #1;
        verifica("cfg_ok", int'(erro_config), 0);

        // Reset mid-fill discards partial counts
        amostras(6'd30, 3);
        verifica("rf_enchendo", int'(db_estado), 1);
        amostras(6'd10, 2);
        reset = 1'b0;
        @(posedge clock);
        #1;
        verifica("rf_valv",   int'(valvula),   0);
        verifica("rf_estado", int'(db_estado), 0);
        reset = 1'b1;
        amostras(6'd30, 2);
        verifica("rf_parcial", int'(db_estado), 0);
        amostra(6'd30);
        verifica("rf_reenche", int'(db_estado), 1);
        amostras(6'd10, 2);
        verifica("rf_conf_limpo", int'(db_estado), 1);

        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

endmodule
